multi_port_comparator: RTL and testbench

MULTI_PORT_COMPARATOR -- requirements
Module: multi_port_comparator

---
 rtl/multi_port_comparator_pkg.sv | 17 +
 rtl/multi_port_comparator_matcher.sv | 37 +++
 rtl/multi_port_comparator.sv | 136 +++++++++++++
 tb/tb_multi_port_comparator.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/multi_port_comparator_pkg.sv
// Shared defaults and helpers for the multi-port stream comparator.
// Holds width/latency defaults and the match-index width function.
package port_cmp_pkg;

    localparam int DEF_DATA_W   = 32;
    localparam int DEF_KEY_W    = 16;
    localparam int DEF_NUM_KEYS = 4;
    localparam int DEF_LATENCY  = 2;
    localparam int BYTE_W       = 8;
    localparam int CNT_W        = 8;

    // Width of an index into n entries, never below one bit.
    function automatic int idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/multi_port_comparator_matcher.sv
// key_window_matcher: combinational search of one key in a two-word window.
// Ports: i_window (prev word & current word), i_key, i_en, i_valid, i_hist_v -> o_hit.
module key_window_matcher
    import port_cmp_pkg::*;
#(
    parameter int DATA_W = DEF_DATA_W,
    parameter int KEY_W  = DEF_KEY_W
) (
    input  logic [2*DATA_W-1:0] i_window,
    input  logic [KEY_W-1:0]    i_key,
    input  logic                i_en,
    input  logic                i_valid,
    input  logic                i_hist_v,
    output logic                o_hit
);

    localparam int NB = DATA_W / BYTE_W;
    localparam int KB = KEY_W / BYTE_W;
    // First window byte offset whose last key byte lands in the current word.
    localparam int J0 = NB - KB + 1;

    logic w_any;

    always_comb begin
        w_any = 1'b0;
        for (int o = 0; o < NB; o++) begin
            // Offsets starting in the previous word need valid history.
            if ((i_window[2*DATA_W-1-(J0+o)*BYTE_W -: KEY_W] == i_key) &&
                ((J0 + o >= NB) || i_hist_v)) begin
                w_any = 1'b1;
            end
        end
    end

    assign o_hit = w_any & i_en & i_valid;

endmodule

// File: rtl/multi_port_comparator.sv
// multi_port_comparator: delays a byte stream and flags per-key byte matches.
// Ports: clk/rst/clear, data_valid/data_in, keys/key_en/sticky_mode -> data_out(_valid), match_*.
module multi_port_comparator
    import port_cmp_pkg::*;
#(
    parameter int DATA_W   = DEF_DATA_W,
    parameter int KEY_W    = DEF_KEY_W,
    parameter int NUM_KEYS = DEF_NUM_KEYS,
    parameter int LATENCY  = DEF_LATENCY
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          clear,
    input  logic                          data_valid,
    input  logic [DATA_W-1:0]             data_in,
    input  logic [NUM_KEYS*KEY_W-1:0]     keys,
    input  logic [NUM_KEYS-1:0]           key_en,
    input  logic                          sticky_mode,
    output logic [DATA_W-1:0]             data_out,
    output logic                          data_out_valid,
    output logic [NUM_KEYS-1:0]           match_vec,
    output logic                          match,
    output logic [idx_w(NUM_KEYS)-1:0]    match_idx,
    output logic [NUM_KEYS*CNT_W-1:0]     match_count
);

    localparam int IDX_W = idx_w(NUM_KEYS);

    logic [DATA_W-1:0]                  r_hist;
    logic                               r_hist_v;
    logic [2*DATA_W-1:0]                w_window;
    logic [NUM_KEYS-1:0]                w_hit;
    logic [NUM_KEYS-1:0]                w_emerge;
    logic [DATA_W-1:0]                  r_dat [LATENCY];
    logic                               r_vld [LATENCY];
    logic [NUM_KEYS-1:0]                r_mv;
    logic [NUM_KEYS-1:0][CNT_W-1:0]     r_cnt;

    assign w_window = {r_hist, data_in};

    for (genvar g = 0; g < NUM_KEYS; g++) begin : gen_match
        key_window_matcher #(
            .DATA_W (DATA_W),
            .KEY_W  (KEY_W)
        ) u_match (
            .i_window (w_window),
            .i_key    (keys[g*KEY_W +: KEY_W]),
            .i_en     (key_en[g]),
            .i_valid  (data_valid),
            .i_hist_v (r_hist_v),
            .o_hit    (w_hit[g])
        );
    end

    // Hit bits ride LATENCY-1 stages; flags/counters form the last stage
    // so they line up with data_out.
    if (LATENCY == 1) begin : gen_hp0
        assign w_emerge = w_hit;
    end else begin : gen_hp
        logic [NUM_KEYS-1:0] r_hp [LATENCY-1];

        always_ff @(posedge clk) begin
            if (rst || clear) begin
                for (int i = 0; i < LATENCY - 1; i++) begin
                    r_hp[i] <= '0;
                end
            end else begin
                r_hp[0] <= w_hit;
                for (int i = 1; i < LATENCY - 1; i++) begin
                    r_hp[i] <= r_hp[i-1];
                end
            end
        end

        assign w_emerge = r_hp[LATENCY-2];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist   <= '0;
            r_hist_v <= 1'b0;
            r_mv     <= '0;
            r_cnt    <= '0;
            for (int i = 0; i < LATENCY; i++) begin
                r_dat[i] <= '0;
                r_vld[i] <= 1'b0;
            end
        end else begin
            // Data contents keep shifting through a flush; only valids drop.
            r_dat[0] <= data_in;
            for (int i = 1; i < LATENCY; i++) begin
                r_dat[i] <= r_dat[i-1];
            end
            if (clear) begin
                r_hist   <= '0;
                r_hist_v <= 1'b0;
                r_mv     <= '0;
                r_cnt    <= '0;
                for (int i = 0; i < LATENCY; i++) begin
                    r_vld[i] <= 1'b0;
                end
            end else begin
                r_vld[0] <= data_valid;
                for (int i = 1; i < LATENCY; i++) begin
                    r_vld[i] <= r_vld[i-1];
                end
                if (data_valid) begin
                    r_hist   <= data_in;
                    r_hist_v <= 1'b1;
                end
                r_mv <= sticky_mode ? (r_mv | w_emerge) : w_emerge;
                for (int k = 0; k < NUM_KEYS; k++) begin
                    if (w_emerge[k] && (r_cnt[k] != {CNT_W{1'b1}})) begin
                        r_cnt[k] <= r_cnt[k] + 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        match_idx = '0;
        for (int k = NUM_KEYS - 1; k >= 0; k--) begin
            if (r_mv[k]) begin
                match_idx = IDX_W'(k);
            end
        end
    end

    assign data_out       = r_dat[LATENCY-1];
    assign data_out_valid = r_vld[LATENCY-1];
    assign match_vec      = r_mv;
    assign match          = |r_mv;
    assign match_count    = r_cnt;

endmodule

// File: tb/tb_multi_port_comparator.sv
// Scoreboard bench for multi_port_comparator with default parameters.
// Reference model predicts every output cycle; directed checks pin key cases.
module tb_multi_port_comparator;

    localparam int DW  = 32;
    localparam int KW  = 16;
    localparam int NK  = 4;
    localparam int LAT = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          clear = 1'b0;
    logic          data_valid = 1'b0;
    logic [DW-1:0] data_in = '0;
    logic [NK*KW-1:0] keys = '0;
    logic [NK-1:0] key_en = '0;
    logic          sticky_mode = 1'b0;
    logic [DW-1:0] data_out;
    logic          data_out_valid;
    logic [NK-1:0] match_vec;
    logic          match;
    logic [1:0]    match_idx;
    logic [NK*8-1:0] match_count;

    multi_port_comparator #(
        .DATA_W   (DW),
        .KEY_W    (KW),
        .NUM_KEYS (NK),
        .LATENCY  (LAT)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .clear          (clear),
        .data_valid     (data_valid),
        .data_in        (data_in),
        .keys           (keys),
        .key_en         (key_en),
        .sticky_mode    (sticky_mode),
        .data_out       (data_out),
        .data_out_valid (data_out_valid),
        .match_vec      (match_vec),
        .match          (match),
        .match_idx      (match_idx),
        .match_count    (match_count)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic          v;
        logic [DW-1:0] d;
        logic [NK-1:0] h;
    } ent_t;

    ent_t          q[$];
    logic [DW-1:0] m_hist;
    logic          m_hv;
    logic [NK-1:0] m_mv;
    int            m_cnt [NK];
    int            n_chk = 0;
    int            n_pass = 0;

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    endtask

    function automatic logic [NK-1:0] model_hits(input logic [DW-1:0] d);
        logic [7:0]    w [8];
        logic [NK-1:0] h;
        logic [KW-1:0] key;
        h = '0;
        for (int b = 0; b < 4; b++) begin
            w[b]   = m_hist[31-8*b -: 8];
            w[4+b] = d[31-8*b -: 8];
        end
        for (int k = 0; k < NK; k++) begin
            key = keys[k*KW +: KW];
            for (int s = 3; s <= 6; s++) begin
                if (key_en[k] && (s >= 4 || m_hv) &&
                    w[s] == key[15:8] && w[s+1] == key[7:0]) h[k] = 1'b1;
            end
        end
        return h;
    endfunction

    task automatic step();
        ent_t e;
        ent_t o;
        logic r;
        logic c;
        logic [1:0] ei;
        r = rst;
        c = clear;
        e = '0;
        if (r) begin
            q.delete();
            for (int i = 0; i < LAT; i++) q.push_back(e);
            m_hist = '0;
            m_hv = 1'b0;
        end else if (c) begin
            foreach (q[i]) begin
                q[i].v = 1'b0;
                q[i].h = '0;
            end
            q.push_back(e);
            m_hist = '0;
            m_hv = 1'b0;
        end else begin
            e.v = data_valid;
            e.d = data_in;
            e.h = data_valid ? model_hits(data_in) : '0;
            q.push_back(e);
            if (data_valid) begin
                m_hist = data_in;
                m_hv = 1'b1;
            end
        end
        @(posedge clk);
        o = q.pop_front();
        if (r || c) begin
            m_mv = '0;
            for (int k = 0; k < NK; k++) m_cnt[k] = 0;
        end else begin
            m_mv = sticky_mode ? (m_mv | o.h) : o.h;
            for (int k = 0; k < NK; k++)
                if (o.h[k] && m_cnt[k] < 255) m_cnt[k]++;
        end
        #1;
        ei = 2'd0;
        for (int k = NK - 1; k >= 0; k--) if (m_mv[k]) ei = 2'(k);
        chk("dov", 64'(data_out_valid), 64'(o.v));
        if (o.v || r) chk("dout", 64'(data_out), 64'(o.d));
        chk("mvec", 64'(match_vec), 64'(m_mv));
        chk("match", 64'(match), 64'(|m_mv));
        chk("midx", 64'(match_idx), 64'(ei));
        for (int k = 0; k < NK; k++)
            chk("cnt", 64'(match_count[k*8 +: 8]), 64'(m_cnt[k]));
    endtask

    task automatic drive(input logic v, input logic [DW-1:0] d);
        data_valid = v;
        data_in = d;
        step();
        data_valid = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        data_valid = 1'b0;
        step();
        clear = 1'b0;
    endtask

    task automatic do_rst();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    function automatic logic [7:0] rb();
        case ($urandom_range(0, 4))
            0: return 8'hAB;
            1: return 8'hCD;
            2: return 8'h12;
            3: return 8'h34;
            default: return 8'h00;
        endcase
    endfunction

    initial begin
        m_hist = '0;
        m_hv = 1'b0;
        m_mv = '0;
        for (int k = 0; k < NK; k++) m_cnt[k] = 0;
        step();
        chk("rst_dout", 64'(data_out), 64'h0);
        chk("rst_cnt", 64'(match_count), 64'h0);
        rst = 1'b0;

        keys = {16'h0, 16'h0, 16'h0, 16'hABCD};
        key_en = 4'b0001;
        drive(1, 32'h00ABCD00);
        drive(1, 32'h00000000);
        chk("s37_dout", 64'(data_out), 64'h00ABCD00);
        chk("s37_mv", 64'(match_vec), 64'h1);
        chk("s37_idx", 64'(match_idx), 64'h0);
        chk("s37_cnt", 64'(match_count[7:0]), 64'h1);
        drive(0, 0);

        do_clear();
        drive(1, 32'h000000AB);
        drive(1, 32'hCD000000);
        chk("s38_first", 64'(match_vec), 64'h0);
        drive(1, 32'h0000ABCD);
        chk("s38_cross", 64'(match_vec), 64'h1);
        drive(1, 32'h00000000);
        chk("s38_in", 64'(match_vec), 64'h1);
        drive(0, 0);

        do_rst();
        keys = {16'h0, 16'h0, 16'h0000, 16'h0};
        key_en = 4'b0010;
        drive(1, 32'h00FFFFFF);
        drive(1, 32'h0000FFFF);
        chk("s39_guard", 64'(match_vec), 64'h0);
        drive(0, 0);
        chk("s39_hit", 64'(match_vec), 64'h2);
        chk("s39_idx", 64'(match_idx), 64'h1);
        drive(0, 0);

        do_clear();
        keys = {16'h0, 16'hFFFF, 16'h0, 16'h0};
        key_en = 4'b0100;
        drive(1, 32'hFFFFFFFF);
        drive(1, 32'h00000000);
        chk("s40_pulse", 64'(match), 64'h1);
        drive(0, 0);
        chk("s40_drop", 64'(match), 64'h0);
        sticky_mode = 1'b1;
        do_clear();
        drive(1, 32'hFFFFFFFF);
        drive(1, 32'h00000000);
        drive(0, 0);
        drive(0, 0);
        chk("s40_hold", 64'(match), 64'h1);
        do_clear();
        chk("s40_clr", 64'(match), 64'h0);
        sticky_mode = 1'b0;

        keys = {16'h1234, 16'h0, 16'h0, 16'h1234};
        key_en = 4'b1001;
        drive(1, 32'h00000012);
        drive(0, 0);
        drive(1, 32'h34000000);
        drive(0, 0);
        chk("s41_mv", 64'(match_vec), 64'h9);
        chk("s41_idx", 64'(match_idx), 64'h0);
        for (int i = 0; i < 260; i++) drive(1, 32'h00001234);
        drive(0, 0);
        drive(0, 0);
        chk("s41_sat0", 64'(match_count[7:0]), 64'd255);
        chk("s41_sat3", 64'(match_count[31:24]), 64'd255);

        do_clear();
        keys = {16'h0, 16'h0, 16'h0, 16'hABCD};
        key_en = 4'b0001;
        drive(1, 32'h000000AB);
        do_clear();
        drive(1, 32'hCD000000);
        drive(0, 0);
        chk("s42_clr", 64'(match_vec), 64'h0);
        drive(1, 32'h000000AB);
        do_rst();
        chk("s42_rst_dov", 64'(data_out_valid), 64'h0);
        chk("s42_rst_dout", 64'(data_out), 64'h0);
        drive(1, 32'hCD000000);
        drive(0, 0);
        chk("s42_rst_mv", 64'(match_vec), 64'h0);

        for (int i = 0; i < 400; i++) begin
            if (i % 25 == 0) begin
                keys = {rb(), rb(), rb(), rb(), rb(), rb(), rb(), rb()};
                key_en = 4'($urandom_range(0, 15));
                sticky_mode = 1'($urandom_range(0, 1));
            end
            clear = ($urandom_range(0, 40) == 0);
            rst = ($urandom_range(0, 80) == 0);
            data_valid = ($urandom_range(0, 3) != 0);
            data_in = {rb(), rb(), rb(), rb()};
            step();
            clear = 1'b0;
            rst = 1'b0;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
